// File: rtl/distance_fare_tiered.sv
// distance_fare_tiered: BCD distance meter with tiered per-pulse fare.
// Optional wait-time charging is built when WAIT_FARE_EN is defined.
module distance_fare_tiered #(
  parameter int DIGITS      = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                ten_meter_pulse,
  input  logic                en,
  input  logic                trip_clr,
  input  logic [4*DIGITS-1:0] s_fare,
  input  logic [4*DIGITS-1:0] base_dist,
  input  logic [4*DIGITS-1:0] long_dist,
  input  logic [4*DIGITS-1:0] distance_fare_per_pulse,
  input  logic [4*DIGITS-1:0] long_fare_per_pulse,
`ifdef WAIT_FARE_EN
  input  logic                wait_tick,
  input  logic [4*DIGITS-1:0] wait_fare_bcd,
`endif
  output logic [4*DIGITS-1:0] distance_bcd,
  output logic [4*DIGITS-1:0] distance_fare_bcd,
  output logic                busy,
  output logic                overflow,
  output logic                pulse_drop
);

  localparam int W  = 4 * DIGITS;
  localparam int CW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [W-1:0]  ALL9 = {DIGITS{4'h9}};
  localparam logic [CW-1:0] LAST = CW'(DIGITS - 1);

  typedef enum logic [1:0] {
    IDLE,
    INC,
    ADD,
    COMMIT
  } state_t;

  function automatic logic [W-1:0] clamp9(
    input logic [W-1:0] v
  );
    logic [W-1:0] r;
    r = v;
    for (int i = 0; i < DIGITS; i++) begin
      if (v[4*i +: 4] > 4'd9) r[4*i +: 4] = 4'd9;
    end
    return r;
  endfunction

  // Only called when v is not all nines.
  function automatic logic [W-1:0] bcd_inc(
    input logic [W-1:0] v
  );
    logic [W-1:0] r;
    logic         c;
    r = v;
    c = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (c) begin
        if (v[4*i +: 4] == 4'd9) begin
          r[4*i +: 4] = 4'd0;
        end else begin
          r[4*i +: 4] = v[4*i +: 4] + 4'd1;
          c = 1'b0;
        end
      end
    end
    return r;
  endfunction

  state_t state, state_n;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;
  logic                   edge_req;

  logic [1:0] pend_q, pend_n;
  logic       drop_set;
  logic       q_inc, q_dec;

  logic [W-1:0]  dist_q, fare_q;
  logic [W-1:0]  nd_q, rate_q, acc_q;
  logic [CW-1:0] dig_q;
  logic          carry_q, sat_q;
  logic          ovf_q, drop_q;

  logic dist_req, take_dist, take_wait;

  logic [3:0]   fa, ra, sd;
  logic [4:0]   sum;
  logic         sc;
  logic [W-1:0] acc_add, fare_commit;
  logic [W-1:0] nd_calc, rate_calc;
  logic [W-1:0] b_cl, l_cl;
  logic         nd_sat;

`ifdef WAIT_FARE_EN
  logic wait_q, wait_n, wdrop;
`endif

  // Synchronise the sensor and keep the previous level for edge detect.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], ten_meter_pulse};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign edge_req = sync_q[SYNC_STAGES-1] & ~prev_q & en;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  // Next state; COMMIT dispatches like IDLE so pulses run back to back.
  always_comb begin
    state_n   = state;
    take_dist = 1'b0;
    take_wait = 1'b0;
    dist_req  = edge_req | (pend_q != 2'd0);
    unique case (state)
      IDLE, COMMIT: begin
        state_n = IDLE;
        if (dist_req) begin
          state_n   = INC;
          take_dist = 1'b1;
        end
`ifdef WAIT_FARE_EN
        else if (wait_q) begin
          state_n   = ADD;
          take_wait = 1'b1;
        end
`endif
      end
      INC: state_n = ADD;
      ADD: if (dig_q == LAST) state_n = COMMIT;
      default: state_n = IDLE;
    endcase
    if (trip_clr) begin
      state_n   = IDLE;
      take_dist = 1'b0;
      take_wait = 1'b0;
    end
  end

  // Request queue: an edge that is not served now waits in pend_q.
  always_comb begin
    pend_n   = pend_q;
    drop_set = 1'b0;
    q_inc    = edge_req & ~(take_dist & (pend_q == 2'd0));
    q_dec    = take_dist & (pend_q != 2'd0);
    if (q_inc & ~q_dec) begin
      if (pend_q == 2'd3) drop_set = 1'b1;
      else                pend_n   = pend_q + 2'd1;
    end else if (q_dec & ~q_inc) begin
      pend_n = pend_q - 2'd1;
    end
  end

`ifdef WAIT_FARE_EN
  // Single-entry wait request flag.
  always_comb begin
    wait_n = wait_q & ~take_wait;
    wdrop  = 1'b0;
    if (wait_tick & en) begin
      if (wait_n) wdrop  = 1'b1;
      else        wait_n = 1'b1;
    end
  end
`endif

  // One BCD digit add per cycle, least significant digit first.
  always_comb begin
    fa = 4'd0;
    ra = 4'd0;
    for (int i = 0; i < DIGITS; i++) begin
      if (dig_q == CW'(i)) begin
        fa = acc_q[4*i +: 4];
        ra = rate_q[4*i +: 4];
      end
    end
    sum = {1'b0, fa} + {1'b0, ra} + {4'd0, carry_q};
    sc  = sum > 5'd9;
    sd  = sc ? 4'(sum + 5'd6) : sum[3:0];
    acc_add = acc_q;
    for (int i = 0; i < DIGITS; i++) begin
      if (dig_q == CW'(i)) acc_add[4*i +: 4] = sd;
    end
  end

  assign b_cl    = clamp9(base_dist);
  assign l_cl    = clamp9(long_dist);
  assign nd_sat  = (dist_q == ALL9);
  assign nd_calc = nd_sat ? dist_q : bcd_inc(dist_q);

  // Tier selection for the next distance step.
  always_comb begin
    rate_calc = '0;
    if (nd_sat)
      rate_calc = '0;
    else if (nd_calc > l_cl)
      rate_calc = clamp9(long_fare_per_pulse);
    else if (nd_calc > b_cl)
      rate_calc = clamp9(distance_fare_per_pulse);
  end

  assign fare_commit = carry_q ? ALL9 : acc_q;

  // Shadow registers, digit-serial accumulate and committed results.
  always_ff @(posedge clk) begin
    if (rst) begin
      pend_q  <= 2'd0;
      dist_q  <= '0;
      fare_q  <= '0;
      nd_q    <= '0;
      rate_q  <= '0;
      acc_q   <= '0;
      dig_q   <= '0;
      carry_q <= 1'b0;
      sat_q   <= 1'b0;
      ovf_q   <= 1'b0;
      drop_q  <= 1'b0;
`ifdef WAIT_FARE_EN
      wait_q  <= 1'b0;
`endif
    end else if (trip_clr) begin
      pend_q  <= 2'd0;
      dist_q  <= '0;
      fare_q  <= clamp9(s_fare);
      dig_q   <= '0;
      carry_q <= 1'b0;
      sat_q   <= 1'b0;
      ovf_q   <= 1'b0;
      drop_q  <= 1'b0;
`ifdef WAIT_FARE_EN
      wait_q  <= 1'b0;
`endif
    end else begin
      pend_q <= pend_n;
      if (drop_set) drop_q <= 1'b1;
      unique case (state)
        INC: begin
          nd_q    <= nd_calc;
          sat_q   <= nd_sat;
          rate_q  <= rate_calc;
          acc_q   <= fare_q;
          dig_q   <= '0;
          carry_q <= 1'b0;
        end
        ADD: begin
          acc_q   <= acc_add;
          carry_q <= sc;
          dig_q   <= dig_q + 1'b1;
        end
        COMMIT: begin
          dist_q <= nd_q;
          fare_q <= fare_commit;
          if (carry_q | sat_q) ovf_q <= 1'b1;
        end
        default: ;
      endcase
`ifdef WAIT_FARE_EN
      wait_q <= wait_n;
      if (wdrop) drop_q <= 1'b1;
      if (take_wait) begin
        if (state != COMMIT) nd_q <= dist_q;
        sat_q   <= 1'b0;
        rate_q  <= clamp9(wait_fare_bcd);
        acc_q   <= (state == COMMIT) ? fare_commit : fare_q;
        dig_q   <= '0;
        carry_q <= 1'b0;
      end
`endif
    end
  end

  assign distance_bcd      = dist_q;
  assign distance_fare_bcd = fare_q;
  assign overflow          = ovf_q;
  assign pulse_drop        = drop_q;
`ifdef WAIT_FARE_EN
  assign busy = (state != IDLE) | (pend_q != 2'd0) | wait_q;
`else
  assign busy = (state != IDLE) | (pend_q != 2'd0);
`endif

endmodule
